// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALU/mux select codes and the packed control word driven by the state decoder.
package ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'd2;

  localparam logic [SEL_W-1:0] ALUSRCB_B      = 2'd0;
  localparam logic [SEL_W-1:0] ALUSRCB_FOUR   = 2'd1;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM    = 2'd2;
  localparam logic [SEL_W-1:0] ALUSRCB_IMM_SH = 2'd3;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

  // Every datapath enable/select for one state, plus the retire marker.
  typedef struct packed {
    logic               pcwrite;
    logic               pcwritecond;
    logic               iord;
    logic               memread;
    logic               memwrite;
    logic               irwrite;
    logic               memtoreg;
    logic               regdst;
    logic               regwrite;
    logic               alusrca;
    logic [SEL_W-1:0]   alusrcb;
    logic [ALUOP_W-1:0] aluop;
    logic [SEL_W-1:0]   pcsource;
    logic               done;
  } ctrl_t;

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational Moore decode: current state to the full control word.
// ADDIEX/ADDIWB decode only when MAIN_CTRL_ADDI_EN is defined.
module main_ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.irwrite  = 1'b1;
        ctrl.pcwrite  = 1'b1;
        ctrl.alusrcb  = ALUSRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alusrcb = ALUSRCB_IMM_SH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.done     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.done     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.done     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = ALUSRCB_B;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
        ctrl.done        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
        ctrl.done     = 1'b1;
      end
`ifdef MAIN_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.done     = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: next-state sequencing and sticky IllegalOp flag;
// per-state outputs come from main_ctrl_decode. Optional addi support: MAIN_CTRL_ADDI_EN.
module main_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    Op,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [SEL_W-1:0]   PCSource,
  output logic [STATE_W-1:0] State,
  output logic               InstrDone,
  output logic               IllegalOp
);

  state_t state;
  state_t state_nxt;
  logic   illegal_c;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; unused encodings (and addi states when compiled out) fall back to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    illegal_c = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI: begin
`ifdef MAIN_CTRL_ADDI_EN
            state_nxt = S_ADDIEX;
`else
            illegal_c = 1'b1;
`endif
          end
          default:      illegal_c = 1'b1;
        endcase
      end
      S_MEMADR:  state_nxt = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nxt = S_MEMWB;
      S_EXEC:    state_nxt = S_RTYPEWB;
`ifdef MAIN_CTRL_ADDI_EN
      S_ADDIEX:  state_nxt = S_ADDIWB;
`endif
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IllegalOp <= 1'b0;
    end else if (illegal_c) begin
      IllegalOp <= 1'b1;
    end
  end

  main_ctrl_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign PCWrite     = ctrl.pcwrite;
  assign PCWriteCond = ctrl.pcwritecond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign IRWrite     = ctrl.irwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign RegDst      = ctrl.regdst;
  assign RegWrite    = ctrl.regwrite;
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign PCSource    = ctrl.pcsource;
  assign State       = state;
  // An illegal opcode retires in DECODE.
  assign InstrDone   = ctrl.done | illegal_c;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: walks each instruction class state by state,
// checking State, every control output, InstrDone and IllegalOp against hand tables.
module tb_main_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] State;
  logic       InstrDone;
  logic       IllegalOp;

  int   checks;
  int   errors;
  logic exp_ill;

  main_ctrl_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .Op          (Op),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .InstrDone   (InstrDone),
    .IllegalOp   (IllegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  wire [16:0] obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-written control table, same field order as obs.
  function automatic logic [16:0] ctrl_exp(input int s);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb;
    logic [2:0] aop;
    logic [1:0] pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'd0; aop = 3'd0; pcs = 2'd0;
    case (s)
      0:  begin mrd = 1; irw = 1; pcw = 1; srcb = 2'd1; end
      1:  srcb = 2'd3;
      2:  begin srca = 1; srcb = 2'd2; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 3'd2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 3'd1; pcwc = 1; pcs = 2'd1; end
      9:  begin pcw = 1; pcs = 2'd2; end
      10: begin srca = 1; srcb = 2'd2; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs};
  endfunction

  task automatic check_cycle(input string tag, input int s, input logic done);
    check({tag, ".state"}, 32'(State), 32'(s));
    check({tag, ".ctrl"}, 32'(obs), 32'(ctrl_exp(s)));
    check({tag, ".done"}, 32'(InstrDone), 32'(done));
    check({tag, ".illegal"}, 32'(IllegalOp), 32'(exp_ill));
  endtask

  // seq packs expected states 4 bits each, first state in the low nibble.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic [19:0] seq, input int n);
    Op = op;
    for (int i = 0; i < n; i++) begin
      int s;
      s = int'(seq[4*i +: 4]);
      check_cycle($sformatf("%s[%0d]", tag, i), s, (i == n - 1));
      @(posedge clk);
      @(negedge clk);
      if (i == n - 1 && s == 1) exp_ill = 1'b1;
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_ill = 1'b0;
    rst     = 1'b1;
    Op      = 6'h00;
    repeat (2) @(negedge clk);
    check_cycle("reset", 0, 1'b0);
    rst = 1'b0;

    run_instr("lw",   6'h23, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5);
    run_instr("rtype", 6'h00, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4);
    run_instr("beq",  6'h04, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 3);
    run_instr("j",    6'h02, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 3);
    run_instr("sw",   6'h2B, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 4);
`ifdef MAIN_CTRL_ADDI_EN
    run_instr("addi", 6'h08, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}, 4);
`else
    run_instr("addi_ill", 6'h08, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 2);
    check("addi_ill.sticky", 32'(IllegalOp), 32'd1);
    // Clear the flag so the 0x3F case below sees a clean rising edge.
    rst = 1'b1;
    #1;
    exp_ill = 1'b0;
    check("addi_ill.clear", 32'(IllegalOp), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif
    run_instr("illegal", 6'h3F, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 2);
    run_instr("rtype_sticky", 6'h00, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 4);
    run_instr("j_sticky", 6'h02, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 3);

    // Reset asserted mid-lw in MEMRD must act without a clock edge.
    Op = 6'h23;
    check_cycle("mid.f", 0, 1'b0);
    @(posedge clk); @(negedge clk);
    check_cycle("mid.d", 1, 1'b0);
    @(posedge clk); @(negedge clk);
    check_cycle("mid.a", 2, 1'b0);
    @(posedge clk); @(negedge clk);
    check_cycle("mid.r", 3, 1'b0);
    rst = 1'b1;
    #1;
    exp_ill = 1'b0;
    check_cycle("mid.rst", 0, 1'b0);
    @(posedge clk); @(negedge clk);
    check_cycle("mid.hold", 0, 1'b0);
    rst = 1'b0;
    run_instr("beq_after_rst", 6'h04, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 3);
    check_cycle("final", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_ctrl_fsm.md
# main_ctrl_fsm

Main control state machine of the multicycle MIPS processor. Sequences each instruction through fetch, decode, execute, memory and write-back steps, driving every datapath enable and mux select. It is the producer of the ALUOp code consumed by the ALU control decoder, and of all PC, memory and register-file controls. It retires exactly one instruction per pass through FETCH.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high; one clock domain
- Op  in  6  opcode field, IR[31:26], stable from DECODE onward
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU Zero
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination: 0 = rt, 1 = rd
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  0 = B, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- ALUOp  out  3  0 = add, 1 = subtract, 2 = use Funct
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- State  out  4  current state, debug
- InstrDone  out  1  one-cycle pulse on the last cycle of each instruction
- IllegalOp  out  1  sticky flag: unsupported opcode seen

## Operation
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RTYPEWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE dispatches on Op:
    - 0x00→EXEC
    - 0x23 lw / 0x2B sw→MEMADR
    - 0x04→BRANCH
    - 0x02→JUMP
    - 0x08→ADDIEX
    - any other→FETCH, sets IllegalOp
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - EXEC→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BRANCH, JUMP and ADDIWB→FETCH.
- Moore outputs. Every output not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite; ALUSrcB=1; ALUOp=0; PCSource=0.
  - DECODE: ALUSrcB=3; ALUOp=0.
  - MEMADR, ADDIEX: ALUSrcA=1; ALUSrcB=2; ALUOp=0.
  - MEMRD: MemRead, IorD.
  - MEMWR: MemWrite, IorD.
  - MEMWB: RegWrite, MemtoReg.
  - EXEC: ALUSrcA=1; ALUSrcB=0; ALUOp=2.
  - RTYPEWB: RegWrite, RegDst.
  - ADDIWB: RegWrite only.
  - BRANCH: ALUSrcA=1; ALUSrcB=0; ALUOp=1; PCWriteCond; PCSource=1.
  - JUMP: PCWrite; PCSource=2.
- InstrDone is asserted in MEMWB, MEMWR, RTYPEWB, ADDIWB, BRANCH and JUMP, and in DECODE when the opcode is illegal.
- IllegalOp is cleared only by rst.

## Timing
- State register updates on the rising edge. Outputs decode from the current state and appear in the same cycle, with no added latency.
- Cycle counts:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- rst asserted at any time, including mid-instruction, forces State=FETCH and IllegalOp=0 immediately. While rst is high, outputs show FETCH values: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=1, everything else 0. The datapath is responsible for holding PC and IR in reset.
- The first rising edge after rst deasserts moves the FSM to DECODE.
- Op is sampled only in DECODE and MEMADR.

## Configuration
- MAIN_CTRL_ADDI_EN defined: ADDIEX and ADDIWB exist, and opcode 0x08 dispatches to ADDIEX.
- MAIN_CTRL_ADDI_EN undefined: states 10 and 11 are absent, and 0x08 is handled as illegal.
- Unused encodings, including 10 and 11 when addi is excluded, recover to FETCH on the next edge.

## Structure
- Shared package ctrl_pkg holds:
  - state encodings
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp codes ALUOP_ADD=0, ALUOP_SUB=1, ALUOP_FUNCT=2
  - ALUSrcB and PCSource select codes
- One sub-module, main_ctrl_decode: purely combinational, state in, all control outputs out. It keeps the FSM core to next-state logic and the IllegalOp flag.

## Test plan
- Reset then Op=0x23 → States 0,1,2,3,4. ALUOp=0 in FETCH and MEMADR. MemRead=1 and IorD=1 in MEMRD. RegWrite=1 and MemtoReg=1 in MEMWB. InstrDone pulses once.
- Op=0x00 → States 0,1,6,7. ALUOp=2 in EXEC. RegDst=1 and RegWrite=1 in RTYPEWB.
- Op=0x04 → States 0,1,8. ALUOp=1, PCWriteCond=1, PCSource=1 in BRANCH. Op=0x02 → JUMP with PCWrite=1 and PCSource=2.
- Op=0x3F → DECODE returns to FETCH, IllegalOp=1 and stays high through later instructions until rst.
- rst pulsed while in MEMRD → State=0 at once, without waiting for a clock edge. Outputs equal FETCH values. IllegalOp=0.
- Op=0x08 with macro defined → States 0,1,10,11, ALUSrcB=2 in ADDIEX. Without the macro → IllegalOp=1 and return to FETCH.
